// File: rtl/shifter_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shifter_arbiter
// Description : Two requesters share one rotate datapath. The rotate width
//               is W = 2**N bits. Arbitration is round-robin. The request
//               ports and the result port each use a valid/ready handshake.
//               The result sits in a one-entry registered stage. A counter
//               records how many results the consumer has taken.
//
// Ports       : clk          rising-edge clock
//               reset_n      asynchronous active-low reset
//               reqX_valid   requester X presents an operation (X = 0, 1)
//               reqX_ready   requester X operation is taken this cycle
//               reqX_a       requester X operand (W bits)
//               reqX_amt     requester X rotate amount (N bits)
//               reqX_lr      requester X direction: 1 = left, 0 = right
//               res_valid    the result register holds a result
//               res_ready    the consumer takes the result this cycle
//               res_data     rotated word
//               res_id       index of the requester that issued res_data
//               op_count     results consumed since reset (wraps)
//
// Revision    : 1.0 - initial release
// ============================================================================
module shifter_arbiter #(
    parameter int N     = 3,
    parameter int CNT_W = 16,
    localparam int W    = 2 ** N
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_a,
    input  logic [N-1:0]     req0_amt,
    input  logic             req0_lr,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_a,
    input  logic [N-1:0]     req1_amt,
    input  logic             req1_lr,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_data,
    output logic             res_id,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [W-1:0]     r_data;
    logic             r_id;
    logic             r_last_grant;
    logic [CNT_W-1:0] r_count;

    logic             w_gnt_valid;
    logic             w_gnt_id;
    logic             w_can_accept;
    logic             w_accept;
    logic             w_drain;

    logic [W-1:0]     w_sel_a;
    logic [N-1:0]     w_sel_amt;
    logic             w_sel_lr;
    logic [2*W-1:0]   w_dbl;
    logic [2*W-1:0]   w_shl;
    logic [2*W-1:0]   w_shr;
    logic [W-1:0]     w_rot;

    // ------------------------------------------------------------------
    // Round-robin grant. When both requesters are valid, the one that was
    // not granted last wins. last_grant only moves on an accept, so a
    // stalled contention is resolved the same way once the stall clears.
    // ------------------------------------------------------------------
    assign w_gnt_valid = req0_valid | req1_valid;
    assign w_gnt_id    = req1_valid & (~req0_valid | ~r_last_grant);

    // ------------------------------------------------------------------
    // Rotate of the granted operand. Rotating {a,a} by amt and keeping one
    // half gives the wrap-around bits with no special case for amt = 0.
    // ------------------------------------------------------------------
    assign w_sel_a   = w_gnt_id ? req1_a   : req0_a;
    assign w_sel_amt = w_gnt_id ? req1_amt : req0_amt;
    assign w_sel_lr  = w_gnt_id ? req1_lr  : req0_lr;
    assign w_dbl     = {w_sel_a, w_sel_a};
    assign w_shl     = w_dbl << w_sel_amt;
    assign w_shr     = w_dbl >> w_sel_amt;
    assign w_rot     = w_sel_lr ? w_shl[2*W-1:W] : w_shr[W-1:0];

    // ------------------------------------------------------------------
    // Output-stage state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        // The stage can take a new result if it is empty, or if its current
        // result leaves in the same cycle.
        w_can_accept = (r_state == ST_EMPTY) | res_ready;
        w_accept     = w_can_accept & w_gnt_valid;
        w_drain      = (r_state == ST_FULL) & res_ready;
        req0_ready   = w_can_accept & w_gnt_valid & ~w_gnt_id;
        req1_ready   = w_can_accept & w_gnt_valid &  w_gnt_id;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (res_ready && !w_accept) begin
                    w_state_next = ST_EMPTY;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    // ------------------------------------------------------------------
    // Result payload and arbitration history. The payload is kept on a
    // drain, so only an accept changes it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data       <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_data       <= w_rot;
            r_id         <= w_gnt_id;
            r_last_grant <= w_gnt_id;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (w_drain) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign res_valid = (r_state == ST_FULL);
    assign res_data  = r_data;
    assign res_id    = r_id;
    assign op_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_shifter_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_shifter_arbiter
// Description : Self-checking bench for shifter_arbiter. The bench keeps a
//               transaction-level reference model. Directed scenarios run
//               first. A randomized traffic phase follows them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shifter_arbiter;

    localparam int N     = 3;
    localparam int W     = 1 << N;
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset_n;
    logic             req0_valid, req0_ready, req0_lr;
    logic [W-1:0]     req0_a;
    logic [N-1:0]     req0_amt;
    logic             req1_valid, req1_ready, req1_lr;
    logic [W-1:0]     req1_a;
    logic [N-1:0]     req1_amt;
    logic             res_valid, res_ready, res_id;
    logic [W-1:0]     res_data;
    logic [CNT_W-1:0] op_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit           m_valid;
    logic [W-1:0] m_data;
    bit           m_id;
    bit           m_last;
    int           m_count;

    shifter_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_amt   (req0_amt),
        .req0_lr    (req0_lr),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_amt   (req1_amt),
        .req1_lr    (req1_lr),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] rot_ref(input logic [W-1:0] a, input int amt, input logic lr);
        logic [W-1:0] y;
        for (int i = 0; i < W; i++) begin
            if (lr) y[i] = a[(i - amt + W) % W];
            else    y[i] = a[(i + amt) % W];
        end
        return y;
    endfunction

    // Returns the requester that should win now, or -1 if none is valid.
    function automatic int model_grant();
        if (req0_valid && req1_valid) return m_last ? 0 : 1;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    function automatic bit exp_ready(input int x);
        return ((!m_valid) || (res_ready === 1'b1)) && (model_grant() == x);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_data = '0; m_id = 0; m_last = 1; m_count = 0;
    endtask

    task automatic set_idle();
        req0_valid = 0; req0_a = '0; req0_amt = '0; req0_lr = 0;
        req1_valid = 0; req1_a = '0; req1_amt = '0; req1_lr = 0;
        res_ready  = 0;
    endtask

    // Advance one clock. Before the edge, compute what the model should do
    // with the inputs present now. One ns after the edge, commit that result.
    task automatic tick();
        int g;
        bit acc, drn;
        logic [W-1:0] nd;
        g   = model_grant();
        acc = ((!m_valid) || res_ready) && (g >= 0);
        drn = m_valid && res_ready;
        nd  = (g == 1) ? rot_ref(req1_a, int'(req1_amt), req1_lr)
                       : rot_ref(req0_a, int'(req0_amt), req0_lr);
        @(posedge clk);
        #1;
        if (drn) m_count = (m_count + 1) % (1 << CNT_W);
        if (acc) begin
            m_valid = 1; m_data = nd; m_id = g[0]; m_last = g[0];
        end else if (drn) begin
            m_valid = 0;
        end
    endtask

    task automatic do_reset();
        reset_n = 0;
        #2;
        reset_n = 1;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        set_idle();
        reset_n = 0;
        model_reset();
        #1;
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", res_valid); end
        n_checks++; if (res_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 00", res_data); end
        n_checks++; if (res_id !== 1'b0) begin n_fail++; $display("FAIL reset_id: got %b want 0", res_id); end
        n_checks++; if (op_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", op_count); end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
    endtask

    task automatic test_req0_only();
        req0_valid = 1; req0_a = 8'h81; req0_amt = 3'd1; req0_lr = 1; res_ready = 1;
        @(negedge clk);
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL r0only_ready0: got %b want 1", req0_ready); end
        n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL r0only_ready1: got %b want 0", req1_ready); end
        tick();
        req0_valid = 0;
        @(negedge clk);
        n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL r0only_valid: got %b want 1", res_valid); end
        n_checks++; if (res_data !== 8'h03) begin n_fail++; $display("FAIL r0only_data: got %h want 03", res_data); end
        n_checks++; if (res_id !== 1'b0) begin n_fail++; $display("FAIL r0only_id: got %b want 0", res_id); end
        tick();
        @(negedge clk);
        n_checks++; if (op_count !== 4'd1) begin n_fail++; $display("FAIL r0only_count: got %0d want 1", op_count); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL r0only_drained: got %b want 0", res_valid); end
        n_checks++; if (res_data !== 8'h03) begin n_fail++; $display("FAIL r0only_hold: got %h want 03", res_data); end
        tick();
    endtask

    task automatic test_req1_only();
        req1_valid = 1; req1_a = 8'h81; req1_amt = 3'd3; req1_lr = 0; res_ready = 1;
        @(negedge clk);
        n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL r1only_ready1: got %b want 1", req1_ready); end
        tick();
        req1_valid = 0;
        @(negedge clk);
        n_checks++; if (res_data !== 8'h30) begin n_fail++; $display("FAIL r1only_data: got %h want 30", res_data); end
        n_checks++; if (res_id !== 1'b1) begin n_fail++; $display("FAIL r1only_id: got %b want 1", res_id); end
        tick();
        for (int lr = 0; lr < 2; lr++) begin
            req1_valid = 1; req1_a = 8'h5A; req1_amt = 3'd0; req1_lr = lr[0];
            @(negedge clk);
            tick();
            req1_valid = 0;
            @(negedge clk);
            n_checks++; if (res_data !== 8'h5A) begin n_fail++; $display("FAIL amt0_lr%0d: got %h want 5a", lr, res_data); end
            tick();
        end
    endtask

    task automatic test_round_robin();
        int exp_g [4] = '{0, 1, 0, 1};
        set_idle();
        do_reset();
        req0_valid = 1; req1_valid = 1; res_ready = 1;
        for (int k = 0; k < 4; k++) begin
            req0_a = W'($urandom); req0_amt = N'($urandom); req0_lr = 1'($urandom);
            req1_a = W'($urandom); req1_amt = N'($urandom); req1_lr = 1'($urandom);
            @(negedge clk);
            n_checks++; if (req0_ready !== (exp_g[k] == 0)) begin n_fail++; $display("FAIL rr_ready0[%0d]: got %b want %0d", k, req0_ready, exp_g[k] == 0); end
            n_checks++; if (req1_ready !== (exp_g[k] == 1)) begin n_fail++; $display("FAIL rr_ready1[%0d]: got %b want %0d", k, req1_ready, exp_g[k] == 1); end
            if (k > 0) begin
                n_checks++; if (res_valid !== 1'b1 || res_id !== exp_g[k-1][0]) begin n_fail++; $display("FAIL rr_id[%0d]: got v=%b id=%b want v=1 id=%0d", k-1, res_valid, res_id, exp_g[k-1]); end
            end
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        n_checks++; if (res_valid !== 1'b1 || res_id !== 1'b1) begin n_fail++; $display("FAIL rr_id[3]: got v=%b id=%b want v=1 id=1", res_valid, res_id); end
        n_checks++; if (res_data !== m_data) begin n_fail++; $display("FAIL rr_data: got %h want %h", res_data, m_data); end
        tick();
    endtask

    task automatic test_stall();
        bit pre_last;
        req0_valid = 1; req1_valid = 1; res_ready = 1;
        req0_a = W'($urandom); req1_a = W'($urandom);
        @(negedge clk);
        tick();
        pre_last = m_last;
        res_ready = 0;
        for (int k = 0; k < 3; k++) begin
            req0_a = W'($urandom); req0_amt = N'($urandom); req0_lr = 1'($urandom);
            req1_a = W'($urandom); req1_amt = N'($urandom); req1_lr = 1'($urandom);
            @(negedge clk);
            n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b%b want 00", k, req0_ready, req1_ready); end
            n_checks++; if (res_valid !== 1'b1 || res_data !== m_data) begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%b d=%h want v=1 d=%h", k, res_valid, res_data, m_data); end
            tick();
        end
        res_ready = 1;
        @(negedge clk);
        n_checks++; if (req0_ready !== pre_last || req1_ready !== !pre_last) begin n_fail++; $display("FAIL stall_release_grant: got %b%b want %b%b", req1_ready, req0_ready, !pre_last, pre_last); end
        tick();
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        n_checks++; if (res_valid !== 1'b1 || res_id !== !pre_last || res_data !== m_data) begin n_fail++; $display("FAIL stall_release_result: got v=%b id=%b d=%h want v=1 id=%b d=%h", res_valid, res_id, res_data, !pre_last, m_data); end
        tick();
    endtask

    task automatic test_counter_wrap();
        set_idle();
        do_reset();
        res_ready = 1;
        req0_valid = 1;
        for (int k = 0; k < 17; k++) begin
            req0_a = W'($urandom);
            @(negedge clk);
            tick();
        end
        req0_valid = 0;
        @(negedge clk);
        tick();
        @(negedge clk);
        n_checks++; if (op_count !== 4'd1) begin n_fail++; $display("FAIL count_wrap: got %0d want 1", op_count); end
        tick();
    endtask

    task automatic test_async_reset();
        req0_valid = 1; req0_a = 8'hC3; req0_amt = 3'd2; req0_lr = 1; res_ready = 0;
        @(negedge clk);
        tick();
        set_idle();
        @(negedge clk);
        #1;
        reset_n = 0;
        #1;
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b want 0", res_valid); end
        n_checks++; if (res_data !== '0) begin n_fail++; $display("FAIL areset_data: got %h want 00", res_data); end
        n_checks++; if (op_count !== '0) begin n_fail++; $display("FAIL areset_count: got %0d want 0", op_count); end
        #1;
        reset_n = 1;
        model_reset();
        @(posedge clk);
        #1;
        req0_valid = 1; req1_valid = 1; res_ready = 1;
        @(negedge clk);
        n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL areset_first_grant: got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready); end
        tick();
        set_idle();
        @(negedge clk);
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_a = W'($urandom); req0_amt = N'($urandom); req0_lr = 1'($urandom);
            req1_a = W'($urandom); req1_amt = N'($urandom); req1_lr = 1'($urandom);
            res_ready  = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            n_checks++; if (req0_ready !== exp_ready(0)) begin n_fail++; $display("FAIL rnd_ready0[%0d]: got %b want %b", k, req0_ready, exp_ready(0)); end
            n_checks++; if (req1_ready !== exp_ready(1)) begin n_fail++; $display("FAIL rnd_ready1[%0d]: got %b want %b", k, req1_ready, exp_ready(1)); end
            n_checks++; if (res_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", k, res_valid, m_valid); end
            n_checks++; if (res_data !== m_data) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h", k, res_data, m_data); end
            n_checks++; if (res_id !== m_id) begin n_fail++; $display("FAIL rnd_id[%0d]: got %b want %b", k, res_id, m_id); end
            n_checks++; if (op_count !== CNT_W'(m_count)) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", k, op_count, m_count); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_req0_only();
        test_req1_only();
        test_round_robin();
        test_stall();
        test_counter_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
